// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one UART byte transmitter among NUM_REQ
//   byte-stream requesters. One requester owns the transmitter at a time. It
//   keeps ownership for a packet (ended by req_last) or for at most MAX_BURST
//   bytes. It also gives up ownership after HOLD_TIMEOUT idle cycles. Each
//   byte goes to the transmitter with a tx_start / tx_done handshake. Peer
//   flow control (CTS, active-low) gates acceptance of new bytes.
//
// Ports:
//   clk        transmitter-domain clock
//   rst        synchronous, active-high reset
//   req_valid  per-requester byte valid                     [NUM_REQ]
//   req_data   per-requester byte, requester i at           [NUM_REQ*DATA_WIDTH]
//              bits [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last   final byte of a packet, qualified by handshake [NUM_REQ]
//   req_ready  per-requester byte accept (owner only)       [NUM_REQ]
//   CTS        peer flow control, 0 = peer may receive
//   tx_start   one-cycle pulse, transmitter loads tx_data
//   tx_data    byte to transmit, stable from tx_start to tx_done
//   tx_done    one-cycle pulse from transmitter at end of stop bit
//   grant      one-hot current owner, zero when idle        [NUM_REQ]
//   cts_stall  set when the owner has been blocked by CTS for too long
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_BURST    = 16,
    parameter int HOLD_TIMEOUT = 64,
    parameter int CTS_TIMEOUT  = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          CTS,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_done,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          cts_stall
);

    localparam int IDX_W   = (NUM_REQ > 1)      ? $clog2(NUM_REQ)      : 1;
    localparam int IDLE_W  = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam int STALL_W = (CTS_TIMEOUT > 1)  ? $clog2(CTS_TIMEOUT)  : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_REQ - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LIMIT  = IDLE_W'(HOLD_TIMEOUT - 1);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(CTS_TIMEOUT - 1);
    localparam logic [7:0]         BURST_LIMIT = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_LOAD,
        S_WAIT_DONE
    } state_t;

    state_t                  state, state_next;
    logic [IDX_W-1:0]        gidx, gidx_next;        // index of the current owner
    logic [IDX_W-1:0]        rr_ptr, rr_next;        // highest-priority requester
    logic [NUM_REQ-1:0]      grant_next;
    logic [7:0]              burst_cnt, burst_next;
    logic [IDLE_W-1:0]       idle_cnt, idle_next;
    logic [STALL_W-1:0]      stall_cnt, stall_next;
    logic                    cts_stall_next;
    logic                    last_flag, last_next;
    logic [DATA_WIDTH-1:0]   tx_data_next;
    logic                    release_grant;

    logic                    g_valid;
    logic                    g_last;
    logic [DATA_WIDTH-1:0]   g_data;

    logic                    pick_found;
    logic [IDX_W-1:0]        pick_idx;
    logic [IDX_W-1:0]        cand;

    assign g_valid = req_valid[gidx];
    assign g_last  = req_last[gidx];
    assign g_data  = req_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];

    assign tx_start = (state == S_LOAD);

    // Only the owner sees ready, and only while the peer can receive.
    always_comb begin
        req_ready = '0;
        if (state == S_HOLD && !CTS) begin
            req_ready[gidx] = 1'b1;
        end
    end

    // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next     = state;
        gidx_next      = gidx;
        rr_next        = rr_ptr;
        grant_next     = grant;
        burst_next     = burst_cnt;
        idle_next      = idle_cnt;
        last_next      = last_flag;
        tx_data_next   = tx_data;
        release_grant  = 1'b0;
        stall_next     = '0;
        cts_stall_next = 1'b0;

        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    state_next           = S_HOLD;
                    gidx_next            = pick_idx;
                    grant_next           = '0;
                    grant_next[pick_idx] = 1'b1;
                    burst_next           = '0;
                    idle_next            = '0;
                end
            end

            S_HOLD: begin
                if (g_valid && !CTS) begin
                    tx_data_next = g_data;
                    last_next    = g_last;
                    burst_next   = burst_cnt + 8'd1;
                    idle_next    = '0;
                    state_next   = S_LOAD;
                end else if (!g_valid) begin
                    if (idle_cnt == IDLE_LIMIT) begin
                        release_grant = 1'b1;
                    end else begin
                        idle_next = idle_cnt + 1'b1;
                    end
                end else begin
                    // Valid but blocked by CTS: the owner is not idle.
                    idle_next = '0;
                end
            end

            S_LOAD: begin
                state_next = S_WAIT_DONE;
            end

            S_WAIT_DONE: begin
                if (tx_done) begin
                    // A last byte that also fills the burst releases once.
                    if (last_flag || burst_cnt == BURST_LIMIT) begin
                        release_grant = 1'b1;
                    end else begin
                        state_next = S_HOLD;
                        idle_next  = '0;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Release always goes through IDLE, so re-arbitration happens on a
        // later cycle with the releasing requester at lowest priority.
        if (release_grant) begin
            state_next = S_IDLE;
            grant_next = '0;
            rr_next    = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
        end

        // Stall tracking only survives while staying in HOLD with CTS high.
        if (state == S_HOLD && CTS && state_next == S_HOLD) begin
            if (g_valid) begin
                stall_next     = (stall_cnt == STALL_LIMIT) ? stall_cnt : stall_cnt + 1'b1;
                cts_stall_next = cts_stall | (stall_cnt >= STALL_LIMIT);
            end else begin
                stall_next     = stall_cnt;
                cts_stall_next = cts_stall;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            gidx      <= '0;
            rr_ptr    <= '0;
            grant     <= '0;
            burst_cnt <= '0;
            idle_cnt  <= '0;
            stall_cnt <= '0;
            cts_stall <= 1'b0;
            last_flag <= 1'b0;
            tx_data   <= '0;
        end else begin
            state     <= state_next;
            gidx      <= gidx_next;
            rr_ptr    <= rr_next;
            grant     <= grant_next;
            burst_cnt <= burst_next;
            idle_cnt  <= idle_next;
            stall_cnt <= stall_next;
            cts_stall <= cts_stall_next;
            last_flag <= last_next;
            tx_data   <= tx_data_next;
        end
    end

endmodule
